exp4_unidade_controle: RTL and testbench
========================================

# exp4_unidade_controle

Control unit paired with `exp4_fluxo_dados`. It sequences one round of the memory game: it clears the address counter and the switch register, then waits for each player move. On each move it captures the switches and checks the comparator result. It either advances the address or ends the round as hit, miss or timeout. It drives the datapath control inputs and consumes the datapath status outputs.

## Interface
- `TIMEOUT`, default 5000: maximum clock cycles spent waiting for one move before the round ends in timeout. Minimum 2.
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start or restart request, level, sampled in `inicial` and in the three end states.
- `jogada` in 1: raw move strobe, level; the block detects its rising edge.
- `chavesIgualMemoria` in 1: datapath comparator equality result.
- `fimC` in 1: datapath counter terminal count (address 15).
- `zeraC` out 1: clear the address counter, active-high.
- `contaC` out 1: increment the address counter.
- `zeraR` out 1: clear the switch register, active-high.
- `registraR` out 1: load the switch register.
- `pronto` out 1: round finished.
- `acertou` out 1: round ended with all 16 moves correct.
- `errou` out 1: round ended on a wrong move.
- `timeout` out 1: round ended on the wait limit.
- `db_estado` out 4: current state code, for display.

## Operation
- Moore FSM. All outputs decode from the state register only. Unlisted outputs are 0 in each state.
- `inicial` (0000): all outputs 0. `iniciar`=1 → `preparacao`.
- `preparacao` (0001): `zeraC`=1, `zeraR`=1. Unconditional → `espera`.
- `espera` (0010): wait timer increments each cycle.
  - A `jogada` edge → `registra`.
  - Otherwise, timer = TIMEOUT-1 → `fim_timeout`.
  - Otherwise stay.
- `registra` (0011): `registraR`=1. → `comparacao`.
- `comparacao` (0100): priority order:
  - `chavesIgualMemoria`=0 → `fim_errou`.
  - Otherwise `fimC`=1 → `fim_acertou`.
  - Otherwise → `proximo`.
- `proximo` (0101): `contaC`=1. → `espera`.
- `fim_acertou` (1010): `pronto`=1, `acertou`=1.
- `fim_errou` (1110): `pronto`=1, `errou`=1.
- `fim_timeout` (1101): `pronto`=1, `timeout`=1.
- In all three end states: `iniciar`=1 → `preparacao`; otherwise hold.
- Unused state codes → `inicial` on the next clock.
- Edge detector:
  - One flop `jogada_d` samples `jogada` every cycle, in every state.
  - Edge = `jogada` & ~`jogada_d`.
  - Edges outside `espera` are discarded, not queued.
  - Holding `jogada` high yields exactly one edge.
- Wait timer:
  - Width ceil(log2(TIMEOUT)).
  - Cleared to 0 in every state other than `espera`.
  - Never wraps, because the FSM leaves `espera` at TIMEOUT-1.
- Edge and timer expiry in the same cycle: the edge wins and the FSM goes to `registra`.

## Timing
- Reset (`reset_n`=0):
  - Immediate, not waiting for a clock edge.
  - State `inicial`, `db_estado`=0000, timer 0, `jogada_d` 0, all outputs 0.
  - Reset mid-round abandons the round. No datapath control pulse is emitted during or after reset until `iniciar`.
- `iniciar` high at clock edge k → `zeraC`/`zeraR` high for exactly the cycle after k.
- Control strobes: `zeraC`, `zeraR`, `registraR` and `contaC` are each exactly one cycle wide per visit to their state.
- Move latency:
  - `jogada` rises in cycle n while in `espera` → `registraR` high in cycle n+1.
  - Compare is evaluated in n+2.
  - `contaC` is high in n+3 if the game continues.
  - `chaves` must be stable from cycle n through n+1.
- Synchronous ROM: after `contaC`, at least 2 cycles pass before the next compare (`espera` ≥1 cycle, then `registra`). ROM output is therefore valid at `comparacao`.
- Timeout: exactly TIMEOUT consecutive cycles in `espera` (entry cycle counts as 1), then `fim_timeout` on the next edge.
- A full correct round produces 1 `zeraC`, 16 `registraR` and 15 `contaC` pulses.

## Test plan
- Full round:
  - Setup: TIMEOUT=10, datapath model with `chavesIgualMemoria`=1 and `fimC`=1 after 15 increments.
  - Stimulus: pulse `iniciar`, then 16 `jogada` pulses.
  - Response: 16 `registraR` pulses, 15 `contaC` pulses, end in `db_estado`=1010 with `pronto`=`acertou`=1.
- Miss: `chavesIgualMemoria`=0 on the 3rd move → 2 `contaC` pulses, then 1110 with `errou`=1, held until `iniciar`.
- Timeout:
  - TIMEOUT=10, no `jogada` after `preparacao` → `db_estado`=0010 for exactly 10 cycles, then 1101 with `timeout`=1.
  - Edge arriving in the 10th `espera` cycle → `registra` instead.
- Edge detection: `jogada` held high 20 cycles → exactly one `registraR` pulse. `jogada` toggled during `comparacao` → ignored, no extra `registraR`.
- Reset: drive `reset_n`=0 mid-`espera`, between clock edges → `db_estado`=0000 and all outputs 0 immediately. After release, the FSM stays in `inicial` until `iniciar`.
- Restart: from 1110 assert `iniciar` → `zeraC`=`zeraR`=1 for one cycle, then 0010, and flags `pronto`/`errou` drop to 0.

Source files
------------

// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle: control unit for one round of the memory game.
// Sequences counter/register clears, waits for player moves (rising edge of
// jogada), captures switches, checks the comparator and ends the round as
// hit, miss or timeout.
//
// Ports
//   clock, reset_n         : clock (rising edge), async active-low reset
//   iniciar                : start / restart request (level)
//   jogada                 : raw move strobe (level, edge-detected here)
//   chavesIgualMemoria     : datapath comparator equality
//   fimC                   : datapath counter terminal count
//   zeraC, contaC          : address counter clear / increment
//   zeraR, registraR       : switch register clear / load
//   pronto, acertou,
//   errou, timeout         : round status flags
//   db_estado              : current state code for display
module exp4_unidade_controle #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'b0000,
    ST_PREPARACAO  = 4'b0001,
    ST_ESPERA      = 4'b0010,
    ST_REGISTRA    = 4'b0011,
    ST_COMPARACAO  = 4'b0100,
    ST_PROXIMO     = 4'b0101,
    ST_FIM_ACERTOU = 4'b1010,
    ST_FIM_ERROU   = 4'b1110,
    ST_FIM_TIMEOUT = 4'b1101
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic            jogada_d;
  logic            jogada_edge;

  logic zera_c_nx, conta_c_nx, zera_r_nx, registra_r_nx;
  logic pronto_nx, acertou_nx, errou_nx, timeout_nx;

  // Rising edge of the move strobe; only consumed while waiting in espera.
  assign jogada_edge = jogada & ~jogada_d;

  assign db_estado = state;

  // State, wait timer, edge-detect flop and registered Moore outputs.
  // Outputs are registered from the decode of the next state, so they match
  // a decode of the state register cycle for cycle and clear with reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INICIAL;
      timer     <= '0;
      jogada_d  <= 1'b0;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      jogada_d  <= jogada;
      zeraC     <= zera_c_nx;
      contaC    <= conta_c_nx;
      zeraR     <= zera_r_nx;
      registraR <= registra_r_nx;
      pronto    <= pronto_nx;
      acertou   <= acertou_nx;
      errou     <= errou_nx;
      timeout   <= timeout_nx;
    end
  end

  // Next-state, timer and output decode.
  always_comb begin
    state_next    = state;
    timer_next    = '0;
    zera_c_nx     = 1'b0;
    conta_c_nx    = 1'b0;
    zera_r_nx     = 1'b0;
    registra_r_nx = 1'b0;
    pronto_nx     = 1'b0;
    acertou_nx    = 1'b0;
    errou_nx      = 1'b0;
    timeout_nx    = 1'b0;

    case (state)
      ST_INICIAL:    if (iniciar) state_next = ST_PREPARACAO;
      ST_PREPARACAO: state_next = ST_ESPERA;
      ST_ESPERA: begin
        // A move wins over expiry; the timer only advances while staying,
        // so it never reaches TIMEOUT and never wraps.
        if (jogada_edge)              state_next = ST_REGISTRA;
        else if (timer == TIMER_LAST) state_next = ST_FIM_TIMEOUT;
        else                          timer_next = timer + TW'(1);
      end
      ST_REGISTRA:   state_next = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!chavesIgualMemoria) state_next = ST_FIM_ERROU;
        else if (fimC)           state_next = ST_FIM_ACERTOU;
        else                     state_next = ST_PROXIMO;
      end
      ST_PROXIMO:    state_next = ST_ESPERA;
      ST_FIM_ACERTOU,
      ST_FIM_ERROU,
      ST_FIM_TIMEOUT: if (iniciar) state_next = ST_PREPARACAO;
      default:       state_next = ST_INICIAL;
    endcase

    case (state_next)
      ST_PREPARACAO: begin
        zera_c_nx = 1'b1;
        zera_r_nx = 1'b1;
      end
      ST_REGISTRA:   registra_r_nx = 1'b1;
      ST_PROXIMO:    conta_c_nx    = 1'b1;
      ST_FIM_ACERTOU: begin
        pronto_nx  = 1'b1;
        acertou_nx = 1'b1;
      end
      ST_FIM_ERROU: begin
        pronto_nx = 1'b1;
        errou_nx  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto_nx  = 1'b1;
        timeout_nx = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Self-checking bench for exp4_unidade_controle with a small datapath model
// (address counter driven by zeraC/contaC, fimC at address 15).
module tb_exp4_unidade_controle;

  localparam int unsigned TO = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar;
  logic       jogada;
  logic       chaves_igual;
  logic       fim_c;
  logic       zera_c, conta_c, zera_r, registra_r;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  int n_zera  = 0;
  int n_reg   = 0;
  int n_conta = 0;

  logic [3:0] exp_q[$];
  logic [3:0] addr;

  exp4_unidade_controle #(.TIMEOUT(TO)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .iniciar            (iniciar),
    .jogada             (jogada),
    .chavesIgualMemoria (chaves_igual),
    .fimC               (fim_c),
    .zeraC              (zera_c),
    .contaC             (conta_c),
    .zeraR              (zera_r),
    .registraR          (registra_r),
    .pronto             (pronto),
    .acertou            (acertou),
    .errou              (errou),
    .timeout            (timeout),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  // Datapath address counter model.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)     addr <= 4'd0;
    else if (zera_c)  addr <= 4'd0;
    else if (conta_c) addr <= addr + 4'd1;
  end
  assign fim_c = (addr == 4'd15);

  // Pulse counters: count the cycle's output value at the closing edge.
  always @(posedge clock) begin
    if (zera_c)     n_zera  <= n_zera + 1;
    if (registra_r) n_reg   <= n_reg + 1;
    if (conta_c)    n_conta <= n_conta + 1;
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic start_round(input string name);
    iniciar = 1'b1;
    tick();
    total++;
    if ({db_estado, zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout} !== {4'h1, 8'b1100_0000}) begin
      bad++;
      $display("FAIL %s_prep: got st=%h outs=%b expected st=1 outs=11000000", name, db_estado,
               {zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout});
    end
    iniciar = 1'b0;
    tick();
    total++;
    if ({db_estado, zera_c, zera_r} !== {4'h2, 2'b00}) begin
      bad++;
      $display("FAIL %s_espera: got st=%h zc=%b zr=%b expected st=2 zc=0 zr=0", name, db_estado, zera_c, zera_r);
    end
  endtask

  // One move from espera; expected post-compare state goes through the queue.
  task automatic do_move(input bit ok, input bit last);
    logic [3:0] exp_st;
    chaves_igual = ok;
    exp_q.push_back(!ok ? 4'hE : (last ? 4'hA : 4'h5));
    jogada = 1'b1;
    tick();
    total++;
    if ({db_estado, registra_r} !== {4'h3, 1'b1}) begin
      bad++;
      $display("FAIL move_registra: got st=%h regR=%b expected st=3 regR=1", db_estado, registra_r);
    end
    jogada = 1'b0;
    tick();
    total++;
    if (db_estado !== 4'h4) begin
      bad++;
      $display("FAIL move_comparacao: got st=%h expected 4", db_estado);
    end
    tick();
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL move_queue: got empty queue expected an entry");
      exp_st = 4'h5;
    end else begin
      exp_st = exp_q.pop_front();
      if (db_estado !== exp_st) begin
        bad++;
        $display("FAIL move_result: got st=%h expected %h", db_estado, exp_st);
      end
    end
    if (exp_st == 4'h5) begin
      total++;
      if (conta_c !== 1'b1) begin
        bad++;
        $display("FAIL move_contaC: got %b expected 1", conta_c);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; iniciar = 1'b0; jogada = 1'b0; chaves_igual = 1'b1;
    #3;
    total++;
    if ({db_estado, zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got st=%h outs=%b expected all 0", db_estado,
               {zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout});
    end
    tick(); tick();
    reset_n = 1'b1;
    repeat (5) tick();
    total++;
    if ({db_estado, zera_c} !== 5'h00 || n_zera != 0) begin
      bad++;
      $display("FAIL reset_idle: got st=%h zeraC_pulses=%0d expected st=0 pulses=0", db_estado, n_zera);
    end
  endtask

  task automatic test_full_round;
    int r0, c0, z0;
    r0 = n_reg; c0 = n_conta; z0 = n_zera;
    start_round("full");
    for (int i = 0; i < 16; i++) do_move(1'b1, i == 15);
    tick();
    total++;
    if (n_reg - r0 != 16 || n_conta - c0 != 15 || n_zera - z0 != 1) begin
      bad++;
      $display("FAIL full_pulses: got reg=%0d conta=%0d zera=%0d expected 16 15 1", n_reg - r0, n_conta - c0, n_zera - z0);
    end
    total++;
    if ({db_estado, pronto, acertou, errou, timeout} !== {4'hA, 4'b1100}) begin
      bad++;
      $display("FAIL full_end: got st=%h flags=%b expected st=a flags=1100", db_estado, {pronto, acertou, errou, timeout});
    end
  endtask

  task automatic test_miss;
    int c0;
    start_round("miss");
    c0 = n_conta;
    do_move(1'b1, 1'b0);
    do_move(1'b1, 1'b0);
    do_move(1'b0, 1'b0);
    repeat (5) tick();
    total++;
    if (n_conta - c0 != 2) begin
      bad++;
      $display("FAIL miss_conta: got %0d expected 2", n_conta - c0);
    end
    total++;
    if ({db_estado, pronto, acertou, errou, timeout} !== {4'hE, 4'b1010}) begin
      bad++;
      $display("FAIL miss_hold: got st=%h flags=%b expected st=e flags=1010", db_estado, {pronto, acertou, errou, timeout});
    end
  endtask

  task automatic test_restart;
    iniciar = 1'b1;
    tick();
    total++;
    if ({db_estado, zera_c, zera_r, pronto, errou} !== {4'h1, 4'b1100}) begin
      bad++;
      $display("FAIL restart_prep: got st=%h zc=%b zr=%b pronto=%b errou=%b expected st=1 1 1 0 0",
               db_estado, zera_c, zera_r, pronto, errou);
    end
    iniciar = 1'b0;
    tick();
    total++;
    if ({db_estado, zera_c, zera_r, pronto, errou} !== {4'h2, 4'b0000}) begin
      bad++;
      $display("FAIL restart_espera: got st=%h outs=%b expected st=2 outs=0000", db_estado, {zera_c, zera_r, pronto, errou});
    end
  endtask

  // Entered at the first espera cycle.
  task automatic test_timeout;
    int cnt;
    cnt = 1;
    for (int i = 0; i < 30 && db_estado == 4'h2; i++) begin
      tick();
      if (db_estado == 4'h2) cnt++;
    end
    total++;
    if (cnt != int'(TO)) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TO);
    end
    total++;
    if ({db_estado, pronto, timeout, errou, acertou} !== {4'hD, 4'b1100}) begin
      bad++;
      $display("FAIL timeout_end: got st=%h flags=%b expected st=d flags=1100", db_estado, {pronto, timeout, errou, acertou});
    end
  endtask

  task automatic test_timeout_edge;
    logic [3:0] exp_st;
    start_round("to_edge");
    repeat (TO - 1) tick();
    total++;
    if (db_estado !== 4'h2) begin
      bad++;
      $display("FAIL to_edge_still: got st=%h expected 2", db_estado);
    end
    chaves_igual = 1'b1;
    exp_q.push_back(4'h3);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    exp_st = exp_q.pop_front();
    total++;
    if (db_estado !== exp_st) begin
      bad++;
      $display("FAIL to_edge_wins: got st=%h expected %h", db_estado, exp_st);
    end
    tick(); tick(); tick();
    total++;
    if (db_estado !== 4'h2) begin
      bad++;
      $display("FAIL to_edge_resume: got st=%h expected 2", db_estado);
    end
  endtask

  task automatic test_edge_hold;
    int r0;
    start_round("hold");
    r0 = n_reg;
    chaves_igual = 1'b1;
    jogada = 1'b1;
    repeat (20) tick();
    jogada = 1'b0;
    tick();
    total++;
    if (n_reg - r0 != 1) begin
      bad++;
      $display("FAIL hold_pulses: got %0d expected 1", n_reg - r0);
    end
    total++;
    if (db_estado !== 4'hD) begin
      bad++;
      $display("FAIL hold_end: got st=%h expected d", db_estado);
    end
  endtask

  task automatic test_toggle_comparacao;
    int r0;
    start_round("toggle");
    r0 = n_reg;
    chaves_igual = 1'b1;
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    total++;
    if (db_estado !== 4'h4) begin
      bad++;
      $display("FAIL toggle_comp: got st=%h expected 4", db_estado);
    end
    jogada = 1'b1;
    tick();
    tick();
    jogada = 1'b0;
    tick();
    tick();
    total++;
    if (n_reg - r0 != 1 || db_estado !== 4'h2) begin
      bad++;
      $display("FAIL toggle_ignored: got reg=%0d st=%h expected reg=1 st=2", n_reg - r0, db_estado);
    end
  endtask

  task automatic test_reset_mid;
    int z0, r0, c0;
    // Reset between edges while waiting in espera.
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({db_estado, zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout} !== 12'h000) begin
      bad++;
      $display("FAIL reset_espera: got st=%h outs=%b expected all 0", db_estado,
               {zera_c, zera_r, conta_c, registra_r, pronto, acertou, errou, timeout});
    end
    tick();
    reset_n = 1'b1;
    tick();
    start_round("rst_end");
    do_move(1'b0, 1'b0);
    // Reset between edges while holding a miss result.
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({db_estado, pronto, errou} !== {4'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_end: got st=%h pronto=%b errou=%b expected st=0 0 0", db_estado, pronto, errou);
    end
    tick();
    z0 = n_zera; r0 = n_reg; c0 = n_conta;
    reset_n = 1'b1;
    repeat (6) tick();
    total++;
    if (db_estado !== 4'h0 || n_zera != z0 || n_reg != r0 || n_conta != c0) begin
      bad++;
      $display("FAIL reset_quiet: got st=%h pulses=%0d/%0d/%0d expected st=0 no pulses", db_estado,
               n_zera - z0, n_reg - r0, n_conta - c0);
    end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_miss();
    test_restart();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    start_round("post_reset");
    test_timeout();
    test_edge_hold();
    test_toggle_comparacao();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
